// File: rtl/output_vc_status_tracker_if.sv
// Allocator/crossbar/link-facing signals of one output port's VC status tracker.
// master drives grants, flit strobes and credits; slave is the tracker itself.
interface output_vc_status_tracker_if #(
  parameter int unsigned V = 4
);
  logic [V-1:0] ovc_allocated;
  logic [V-1:0] flit_out_wr;
  logic         flit_out_is_tail;
  logic [V-1:0] credit_in;
  logic [V-1:0] ovc_is_assigned;
  logic [V-1:0] full;
  logic [V-1:0] nearly_full;
  logic [V-1:0] empty;
  logic [V-1:0] avalable_ovc;
  logic         tracker_err;

  modport master (
    output ovc_allocated, flit_out_wr, flit_out_is_tail, credit_in,
    input  ovc_is_assigned, full, nearly_full, empty, avalable_ovc, tracker_err
  );

  modport slave (
    input  ovc_allocated, flit_out_wr, flit_out_is_tail, credit_in,
    output ovc_is_assigned, full, nearly_full, empty, avalable_ovc, tracker_err
  );
endinterface

// File: rtl/output_vc_status_tracker.sv
// Per-output-port downstream VC tracker: credit counters and busy bits per OVC.
// Optional protocol checker enabled by defining OVC_TRACKER_CHECK_EN.
module output_vc_status_tracker #(
  parameter int unsigned V = 4,
  parameter int unsigned B = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output_vc_status_tracker_if.slave     bus
);
  localparam int unsigned   CW      = $clog2(B + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(B);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} vc_state_e;

  vc_state_e     st_q  [V];
  vc_state_e     st_d  [V];
  logic [CW-1:0] cnt_q [V];
  logic [CW-1:0] cnt_d [V];

  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < V; v++) begin
      if (reset) begin
        st_q[v]  <= IDLE;
        cnt_q[v] <= CNT_MAX;
      end else begin
        st_q[v]  <= st_d[v];
        cnt_q[v] <= cnt_d[v];
      end
    end
  end

  // Tail clear is applied after the grant set so a same-cycle single-flit packet ends IDLE.
  always_comb begin
    for (int unsigned v = 0; v < V; v++) begin
      st_d[v]  = st_q[v];
      cnt_d[v] = cnt_q[v];
      if (bus.ovc_allocated[v])
        st_d[v] = BUSY;
      if (bus.flit_out_wr[v] && bus.flit_out_is_tail)
        st_d[v] = IDLE;
      case ({bus.flit_out_wr[v], bus.credit_in[v]})
        2'b10:   if (cnt_q[v] != '0)      cnt_d[v] = cnt_q[v] - 1'b1;
        2'b01:   if (cnt_q[v] != CNT_MAX) cnt_d[v] = cnt_q[v] + 1'b1;
        default: cnt_d[v] = cnt_q[v];
      endcase
    end
  end

  always_comb begin
    bus.ovc_is_assigned = '0;
    bus.full            = '0;
    bus.nearly_full     = '0;
    bus.empty           = '0;
    bus.avalable_ovc    = '0;
    for (int unsigned v = 0; v < V; v++) begin
      bus.ovc_is_assigned[v] = (st_q[v] == BUSY);
      bus.full[v]            = (cnt_q[v] == '0);
      bus.nearly_full[v]     = (cnt_q[v] == CW'(1));
      bus.empty[v]           = (cnt_q[v] == CNT_MAX);
      bus.avalable_ovc[v]    = (st_q[v] == IDLE) && (cnt_q[v] != '0);
    end
  end

`ifdef OVC_TRACKER_CHECK_EN
  logic [V-1:0] v_underflow;
  logic [V-1:0] v_overflow;
  logic [V-1:0] v_realloc;
  logic [V-1:0] v_orphan_wr;
  logic         v_multi_alloc;
  logic         v_multi_wr;
  logic         err_q;

  always_comb begin
    v_underflow = '0;
    v_overflow  = '0;
    v_realloc   = '0;
    v_orphan_wr = '0;
    for (int unsigned v = 0; v < V; v++) begin
      v_underflow[v] = bus.flit_out_wr[v] && !bus.credit_in[v] && (cnt_q[v] == '0);
      v_overflow[v]  = bus.credit_in[v] && !bus.flit_out_wr[v] && (cnt_q[v] == CNT_MAX);
      v_realloc[v]   = bus.ovc_allocated[v] && (st_q[v] == BUSY);
      v_orphan_wr[v] = bus.flit_out_wr[v] && (st_q[v] == IDLE) && !bus.ovc_allocated[v];
    end
    v_multi_alloc = (bus.ovc_allocated & (bus.ovc_allocated - 1'b1)) != '0;
    v_multi_wr    = (bus.flit_out_wr & (bus.flit_out_wr - 1'b1)) != '0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if ((|{v_underflow, v_overflow, v_realloc, v_orphan_wr}) || v_multi_alloc || v_multi_wr)
      err_q <= 1'b1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned v = 0; v < V; v++) begin
        if (v_underflow[v]) $display("ovc_tracker: VC%0d credit underflow", v);
        if (v_overflow[v])  $display("ovc_tracker: VC%0d credit overflow", v);
        if (v_realloc[v])   $display("ovc_tracker: VC%0d allocated while busy", v);
        if (v_orphan_wr[v]) $display("ovc_tracker: VC%0d flit written while unassigned", v);
      end
      if (v_multi_alloc) $display("ovc_tracker: multiple OVCs allocated in one cycle");
      if (v_multi_wr)    $display("ovc_tracker: multiple OVCs written in one cycle");
    end
  end
`endif

  always_comb bus.tracker_err = err_q;
`else
  always_comb bus.tracker_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_vc_status_tracker.sv
// Directed-vector bench for output_vc_status_tracker (V=4, B=4) with a queue scoreboard.
module tb_output_vc_status_tracker;
  logic clk = 1'b0;
  logic reset;

  output_vc_status_tracker_if #(.V(4)) bus ();

  output_vc_status_tracker #(.V(4), .B(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic [3:0] full;
    logic [3:0] nf;
    logic [3:0] empty;
    logic [3:0] avail;
    logic       err;
    int         row;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   row_no = 0;

  task automatic chk(input string name, input int row, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s row=%0d actual=%b required=%b", name, row, act, req);
    end
  endtask

  // One clock of stimulus; the expected outputs after that edge go to the scoreboard.
  task automatic step(input logic rst, input logic [3:0] alloc, input logic [3:0] wr,
                      input logic tail, input logic [3:0] cr,
                      input logic [3:0] st, input logic [3:0] full, input logic [3:0] nf,
                      input logic [3:0] empty, input logic err);
    exp_t e;
    @(negedge clk);
    reset                = rst;
    bus.ovc_allocated    = alloc;
    bus.flit_out_wr      = wr;
    bus.flit_out_is_tail = tail;
    bus.credit_in        = cr;
    @(posedge clk);
    #1;
    e.st    = st;
    e.full  = full;
    e.nf    = nf;
    e.empty = empty;
    e.avail = ~st & ~full;
`ifdef OVC_TRACKER_CHECK_EN
    e.err   = err;
`else
    e.err   = 1'b0;
`endif
    e.row   = row_no;
    row_no++;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ovc_is_assigned", e.row, bus.ovc_is_assigned, e.st);
        chk("full",            e.row, bus.full,            e.full);
        chk("nearly_full",     e.row, bus.nearly_full,     e.nf);
        chk("empty",           e.row, bus.empty,           e.empty);
        chk("avalable_ovc",    e.row, bus.avalable_ovc,    e.avail);
        chk("tracker_err",     e.row, {3'b000, bus.tracker_err}, {3'b000, e.err});
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    bus.ovc_allocated = '0;
    bus.flit_out_wr = '0;
    bus.flit_out_is_tail = 1'b0;
    bus.credit_in = '0;
    //    rst alloc    wr       tl cr       st       full     nf       empty    err
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0);
    step(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0);
    // VC1: allocate, drain all four credits, then one credit back
    step(0, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1111, 0);
    step(0, 4'b0000, 4'b0010, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1101, 0);
    step(0, 4'b0000, 4'b0010, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1101, 0);
    step(0, 4'b0000, 4'b0010, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b1101, 0);
    step(0, 4'b0000, 4'b0010, 0, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b1101, 0);
    step(0, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b1101, 0);
    // VC2 down to two credits, then send+credit together for three cycles
    step(0, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0110, 4'b0000, 4'b0010, 4'b1101, 0);
    step(0, 4'b0000, 4'b0100, 0, 4'b0000, 4'b0110, 4'b0000, 4'b0010, 4'b1001, 0);
    step(0, 4'b0000, 4'b0100, 0, 4'b0000, 4'b0110, 4'b0000, 4'b0010, 4'b1001, 0);
    step(0, 4'b0000, 4'b0100, 0, 4'b0100, 4'b0110, 4'b0000, 4'b0010, 4'b1001, 0);
    step(0, 4'b0000, 4'b0100, 0, 4'b0100, 4'b0110, 4'b0000, 4'b0010, 4'b1001, 0);
    step(0, 4'b0000, 4'b0100, 0, 4'b0100, 4'b0110, 4'b0000, 4'b0010, 4'b1001, 0);
    // VC1 tail with a simultaneous credit, then immediate re-grant
    step(0, 4'b0000, 4'b0010, 1, 4'b0010, 4'b0100, 4'b0000, 4'b0010, 4'b1001, 0);
    step(0, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0110, 4'b0000, 4'b0010, 4'b1001, 0);
    // VC0 single-flit packet: allocate and tail-write in one cycle
    step(0, 4'b0001, 4'b0001, 1, 4'b0000, 4'b0110, 4'b0000, 4'b0010, 4'b1000, 0);
    // VC3 credit overflow at cnt=B: saturates, error sticky when checker built in
    step(0, 4'b0000, 4'b0000, 0, 4'b1000, 4'b0110, 4'b0000, 4'b0010, 4'b1000, 1);
    step(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0110, 4'b0000, 4'b0010, 4'b1000, 1);
    // VC0 busy down to cnt=1, then reset mid-packet
    step(0, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0111, 4'b0000, 4'b0010, 4'b1000, 1);
    step(0, 4'b0000, 4'b0001, 0, 4'b0000, 4'b0111, 4'b0000, 4'b0010, 4'b1000, 1);
    step(0, 4'b0000, 4'b0001, 0, 4'b0000, 4'b0111, 4'b0000, 4'b0011, 4'b1000, 1);
    step(1, 4'b0000, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0);
    step(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0);

    @(negedge clk);
    bus.flit_out_wr = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout actual=running required=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
